ase_pcie_ss_tx_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter merging NUM_PORTS AFU->host AXI-S TLP streams onto one

---
 rtl/ase_pcie_ss_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ase_pcie_ss_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ase_pcie_ss_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-S TLP streams onto one PCIe SS TX
// stream. A grant is held from the first beat of a packet through its tlast; the merged beat
// and its source port sit in a single registered output stage.
module ase_pcie_ss_tx_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned PW          = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             SoftReset,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] in_tuser,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] in_tkeep,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic                             out_tlast,
  output logic [TDATA_WIDTH-1:0]           out_tdata,
  output logic [TUSER_WIDTH-1:0]           out_tuser,
  output logic [TKEEP_WIDTH-1:0]           out_tkeep,
  output logic [PW-1:0]                    out_port,
  output logic                             busy
);

  logic                   locked_q, locked_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   out_tvalid_q, out_tvalid_d;
  logic                   out_tlast_q, out_tlast_d;
  logic [TDATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic [TUSER_WIDTH-1:0] out_tuser_q, out_tuser_d;
  logic [TKEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
  logic [PW-1:0]          out_port_q, out_port_d;

  logic                   slot_free;
  logic [NUM_PORTS-1:0]   blocked;
  logic [NUM_PORTS-1:0]   acc;
  logic                   acc_any;
  logic [PW-1:0]          gnt;
  logic                   sel_tlast;
  logic [TDATA_WIDTH-1:0] sel_tdata;
  logic [TUSER_WIDTH-1:0] sel_tuser;
  logic [TKEEP_WIDTH-1:0] sel_tkeep;
  int unsigned            rr_int;

  // Distance of port idx from the round-robin pointer, walking upward with wrap.
  function automatic int unsigned rr_dist(int unsigned idx, int unsigned ptr);
    return (idx >= ptr) ? (idx - ptr) : (idx + NUM_PORTS - ptr);
  endfunction

  assign slot_free = !out_tvalid_q || out_tready;
  assign rr_int    = 32'(rr_ptr_q);

  // A port is blocked when some other valid port precedes it in round-robin order; this keeps
  // in_tready[i] independent of in_tvalid[i].
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (p != i && in_tvalid[p] && rr_dist(p, rr_int) < rr_dist(i, rr_int)) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the lock owner, or to the first valid port in round-robin order.
  always_comb begin
    in_tready = '0;
    if (!SoftReset && slot_free) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        in_tready[i] = locked_q ? (owner_q == PW'(i)) : !blocked[i];
      end
    end
  end

  assign acc = in_tvalid & in_tready;

  // Encode the accepted port (at most one) and mux its beat.
  always_comb begin
    acc_any   = 1'b0;
    gnt       = '0;
    sel_tlast = 1'b0;
    sel_tdata = '0;
    sel_tuser = '0;
    sel_tkeep = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (acc[i]) begin
        acc_any   = 1'b1;
        gnt       = PW'(i);
        sel_tlast = in_tlast[i];
        sel_tdata = in_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_tuser = in_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        sel_tkeep = in_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH];
      end
    end
  end

  // Next state of the output stage, packet lock and round-robin pointer.
  always_comb begin
    locked_d     = locked_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    out_tdata_d  = out_tdata_q;
    out_tuser_d  = out_tuser_q;
    out_tkeep_d  = out_tkeep_q;
    out_port_d   = out_port_q;
    if (acc_any) begin
      out_tvalid_d = 1'b1;
      out_tlast_d  = sel_tlast;
      out_tdata_d  = sel_tdata;
      out_tuser_d  = sel_tuser;
      out_tkeep_d  = sel_tkeep;
      out_port_d   = gnt;
      if (sel_tlast) begin
        locked_d = 1'b0;
        // Explicit wrap so non-power-of-2 port counts never index past the last port.
        rr_ptr_d = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + PW'(1);
      end else begin
        locked_d = 1'b1;
        owner_d  = gnt;
      end
    end else if (slot_free) begin
      out_tvalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset drops any lock and in-flight beat.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      locked_q     <= 1'b0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      out_tdata_q  <= '0;
      out_tuser_q  <= '0;
      out_tkeep_q  <= '0;
      out_port_q   <= '0;
    end else begin
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      out_tdata_q  <= out_tdata_d;
      out_tuser_q  <= out_tuser_d;
      out_tkeep_q  <= out_tkeep_d;
      out_port_q   <= out_port_d;
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_tlast  = out_tlast_q;
  assign out_tdata  = out_tdata_q;
  assign out_tuser  = out_tuser_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_port   = out_port_q;
  assign busy       = locked_q;

endmodule

// File: tb/tb_ase_pcie_ss_tx_arbiter.sv
// Randomized scoreboard bench for ase_pcie_ss_tx_arbiter: per-port packet sources, a
// rule-level arbitration model that predicts ready and the merged beat stream, and a monitor
// that pops expected beats whenever the DUT hands one downstream.
module tb_ase_pcie_ss_tx_arbiter;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int UW = 10;
  localparam int KW = DW / 8;
  localparam int CW = 640;

  typedef struct packed {
    logic [1:0]    port;
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             SoftReset;
  logic [NP-1:0]    in_tvalid;
  logic [NP-1:0]    in_tready;
  logic [NP-1:0]    in_tlast;
  logic [NP*DW-1:0] in_tdata;
  logic [NP*UW-1:0] in_tuser;
  logic [NP*KW-1:0] in_tkeep;
  logic             out_tvalid;
  logic             out_tready;
  logic             out_tlast;
  logic [DW-1:0]    out_tdata;
  logic [UW-1:0]    out_tuser;
  logic [KW-1:0]    out_tkeep;
  logic [1:0]       out_port;
  logic             busy;

  always #5 clk = ~clk;

  ase_pcie_ss_tx_arbiter #(
    .NUM_PORTS  (NP),
    .TDATA_WIDTH(DW),
    .TUSER_WIDTH(UW)
  ) dut (
    .clk       (clk),
    .SoftReset (SoftReset),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tlast  (in_tlast),
    .in_tdata  (in_tdata),
    .in_tuser  (in_tuser),
    .in_tkeep  (in_tkeep),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast),
    .out_tdata (out_tdata),
    .out_tuser (out_tuser),
    .out_tkeep (out_tkeep),
    .out_port  (out_port),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Source-side state and knobs shared between the main sequence and the driver.
  beat_t         pq[NP][$];
  logic [NP-1:0] started = '0;
  logic [NP-1:0] hs;
  logic [NP-1:0] hold = '0;
  int            tready_pct = 100;
  int            stall_pct = 0;
  int            force_lo = 0;
  int            rst_cycles = 4;
  int            seq = 0;

  task automatic gen_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.data[31:0] = seq;
      b.keep = {$urandom, $urandom};
      b.user = UW'($urandom);
      b.last = (k == len - 1);
      b.port = 2'(p);
      seq++;
      pq[p].push_back(b);
    end
  endtask

  // Driver: retire handshaken beats, apply reset requests, present the next beat per port.
  initial begin
    beat_t b;
    SoftReset  = 1'b1;
    in_tvalid  = '0;
    in_tlast   = '0;
    in_tdata   = '0;
    in_tuser   = '0;
    in_tkeep   = '0;
    out_tready = 1'b0;
    forever begin
      @(negedge clk);
      hs = in_tvalid & in_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p]) begin
          b = pq[p].pop_front();
          started[p] = !b.last;
        end
      end
      if (rst_cycles > 0) begin
        SoftReset = 1'b1;
        rst_cycles--;
        // A reset abandons any partially sent packet; sources start over on a fresh one.
        for (int p = 0; p < NP; p++) begin
          while (started[p] && pq[p].size() > 0) begin
            b = pq[p].pop_front();
            if (b.last) started[p] = 1'b0;
          end
          started[p] = 1'b0;
        end
      end else begin
        SoftReset = 1'b0;
      end
      if (force_lo > 0) begin
        out_tready = 1'b0;
        force_lo--;
      end else begin
        out_tready = ($urandom_range(99) < tready_pct);
      end
      for (int p = 0; p < NP; p++) begin
        if (pq[p].size() > 0 && !hold[p] && $urandom_range(99) >= stall_pct) begin
          b = pq[p][0];
          in_tvalid[p] = 1'b1;
          in_tlast[p]  = b.last;
          in_tdata[p*DW +: DW] = b.data;
          in_tuser[p*UW +: UW] = b.user;
          in_tkeep[p*KW +: KW] = b.keep;
        end else begin
          in_tvalid[p] = 1'b0;
          in_tlast[p]  = 1'b0;
        end
      end
    end
  end

  // Reference model: lock, owner and next-in-turn port tracked as plain integers.
  beat_t   exp_q[$];
  int      m_rr = 0;
  int      m_owner = 0;
  bit      m_locked = 1'b0;
  bit      m_out_v = 1'b0;
  bit      m_slot;
  int      m_g;
  int      n_pushed = 0;
  int      n_dropped = 0;
  int      n_rcv = 0;
  logic [NP-1:0] m_rdy;
  logic [NP-1:0] m_care;
  beat_t   m_e;

  always @(negedge clk) begin
    if (SoftReset) begin
      check("tready_in_reset", in_tready, 0);
      m_rr      = 0;
      m_owner   = 0;
      m_locked  = 1'b0;
      m_out_v   = 1'b0;
      n_dropped += exp_q.size();
      exp_q.delete();
    end else begin
      check("out_tvalid", out_tvalid, m_out_v);
      check("busy", busy, m_locked);
      m_slot = !m_out_v || out_tready;
      m_g = -1;
      if (m_locked) begin
        m_g = m_owner;
      end else begin
        for (int k = 0; k < NP; k++) begin
          if (m_g < 0 && in_tvalid[(m_rr + k) % NP]) m_g = (m_rr + k) % NP;
        end
      end
      m_rdy = '0;
      if (m_slot && m_g >= 0) m_rdy[m_g] = 1'b1;
      m_care = m_locked ? '1 : in_tvalid;
      if (m_care != '0) check("in_tready", in_tready & m_care, m_rdy & m_care);
      if (m_g >= 0 && m_slot && in_tvalid[m_g]) begin
        m_e.port = 2'(m_g);
        m_e.last = in_tlast[m_g];
        m_e.data = in_tdata[m_g*DW +: DW];
        m_e.user = in_tuser[m_g*UW +: UW];
        m_e.keep = in_tkeep[m_g*KW +: KW];
        exp_q.push_back(m_e);
        n_pushed++;
        if (m_e.last) begin
          m_locked = 1'b0;
          m_rr = (m_g + 1) % NP;
        end else begin
          m_locked = 1'b1;
          m_owner = m_g;
        end
        m_out_v = 1'b1;
      end else if (m_slot) begin
        m_out_v = 1'b0;
      end
    end
  end

  // Monitor: compare each delivered beat with the scoreboard; held beats must not change.
  beat_t cur;
  beat_t snap;
  beat_t want;
  bit    stalled_prev = 1'b0;

  always @(negedge clk) begin
    if (SoftReset) begin
      stalled_prev = 1'b0;
    end else begin
      cur = {out_port, out_tlast, out_tuser, out_tkeep, out_tdata};
      if (stalled_prev) check("stable_while_stalled", cur, snap);
      if (out_tvalid && out_tready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("out_beat", cur, want);
          n_rcv++;
        end
      end
      stalled_prev = out_tvalid && !out_tready;
      snap = cur;
    end
  end

  function automatic bit idle();
    int total = 0;
    for (int p = 0; p < NP; p++) total += pq[p].size();
    return (total == 0) && (exp_q.size() == 0) && !out_tvalid;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!idle() && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_done", idle(), 1);
  endtask

  task automatic wait_left(input int p, input int left, input int budget);
    int n = 0;
    while (pq[p].size() > left && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("wait_progress", pq[p].size() <= left, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int total;
    step(6);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_out_tlast", out_tlast, 0);
    check("rst_out_tdata", out_tdata, 0);
    check("rst_out_tuser", out_tuser, 0);
    check("rst_out_tkeep", out_tkeep, 0);
    check("rst_out_port", out_port, 0);
    check("rst_busy", busy, 0);

    // Single multi-beat packet on port 2.
    gen_pkt(2, 3);
    drain(50);

    // Every port holding single-beat packets: strict rotation with no bubbles.
    for (int r = 0; r < 3; r++) for (int p = 0; p < NP; p++) gen_pkt(p, 1);
    drain(100);

    // Port 1 locked on a 4-beat packet while port 0 becomes valid a cycle later.
    gen_pkt(1, 4);
    step(1);
    gen_pkt(0, 1);
    drain(50);

    // Downstream backpressure for 5 cycles mid-packet.
    gen_pkt(2, 4);
    wait_left(2, 2, 50);
    force_lo = 5;
    drain(50);

    // Reset during a 4-beat packet, then port 1 and port 3 compete from a cleared pointer.
    gen_pkt(3, 4);
    wait_left(3, 2, 50);
    rst_cycles = 1;
    step(3);
    gen_pkt(3, 1);
    gen_pkt(1, 1);
    drain(50);

    // Owner bubbles: port 3 drops valid for 3 cycles while port 0 waits.
    gen_pkt(2, 1);
    drain(50);
    gen_pkt(3, 4);
    gen_pkt(0, 1);
    wait_left(3, 3, 50);
    hold[3] = 1'b1;
    step(3);
    hold[3] = 1'b0;
    drain(50);

    // Randomized traffic with source stalls and downstream backpressure.
    tready_pct = 70;
    stall_pct  = 20;
    for (int n = 0; n < 300; n++) begin
      total = 0;
      for (int p = 0; p < NP; p++) total += pq[p].size();
      while (total > 16) begin
        step(1);
        total = 0;
        for (int p = 0; p < NP; p++) total += pq[p].size();
      end
      gen_pkt($urandom_range(NP - 1), $urandom_range(5, 1));
      if ($urandom_range(3) == 0) step(1);
    end
    drain(5000);

    check("beat_count", n_rcv, n_pushed - n_dropped);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
